// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode handshake bundle for the IF/ID buffer.
// master = fetch/decode environment side, slave = buffer side.
interface if_id_buffer_if #(
  parameter int WORD_SIZE = 32
);
  logic [WORD_SIZE-1:0] inPC;
  logic [WORD_SIZE-1:0] inInstruction;
  logic                 inValid;
  logic                 inReady;
  logic                 flush;
  logic [WORD_SIZE-1:0] outPC;
  logic [WORD_SIZE-1:0] outInstruction;
  logic                 outValid;
  logic                 outReady;

  modport master (
    output inPC, inInstruction, inValid, flush, outReady,
    input  inReady, outPC, outInstruction, outValid
  );

  modport slave (
    input  inPC, inInstruction, inValid, flush, outReady,
    output inReady, outPC, outInstruction, outValid
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: circular FIFO of {PC, instruction} with valid/ready
// handshakes on both sides, flush kill and asynchronous active-low reset.
module if_id_buffer #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 2
) (
  input  logic           clk,
  input  logic           rst,
  if_id_buffer_if.slave  bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   W_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   W_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  logic [WORD_SIZE-1:0] r_pc_mem    [DEPTH];
  logic [WORD_SIZE-1:0] r_instr_mem [DEPTH];
  logic [AW-1:0]        r_rd_ptr;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW:0]          r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Both handshake flags come from the registered count only, so there is
  // no combinational path from outReady to inReady.
  assign w_in_ready  = (r_count < W_DEPTH);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.inValid & w_in_ready & ~bus.flush;
  assign w_pop       = w_out_valid & bus.outReady & ~bus.flush;

  assign bus.inReady        = w_in_ready;
  assign bus.outValid       = w_out_valid;
  assign bus.outPC          = w_out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign bus.outInstruction = w_out_valid ? r_instr_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + P_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + W_ONE;
        2'b01:   r_count <= r_count - W_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; stale contents are masked by outValid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= bus.inPC;
      r_instr_mem[r_wr_ptr] <= bus.inInstruction;
    end
  end
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: DEPTH=2 and DEPTH=4 instances share one
// stimulus stream; the DEPTH=4 wrap-around phase uses a small queue model.
module tb_if_id_buffer;
  logic        clk;
  logic        rst;
  logic [31:0] r_in_pc;
  logic [31:0] r_in_instr;
  logic        r_in_valid;
  logic        r_flush;
  logic        r_out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  if_id_buffer_if #(.WORD_SIZE(32)) u_if2 ();
  if_id_buffer_if #(.WORD_SIZE(32)) u_if4 ();

  assign u_if2.inPC          = r_in_pc;
  assign u_if2.inInstruction = r_in_instr;
  assign u_if2.inValid       = r_in_valid;
  assign u_if2.flush         = r_flush;
  assign u_if2.outReady      = r_out_ready;
  assign u_if4.inPC          = r_in_pc;
  assign u_if4.inInstruction = r_in_instr;
  assign u_if4.inValid       = r_in_valid;
  assign u_if4.flush         = r_flush;
  assign u_if4.outReady      = r_out_ready;

  if_id_buffer #(.WORD_SIZE(32), .DEPTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2));
  if_id_buffer #(.WORD_SIZE(32), .DEPTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(u_if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return 32'hC0DE_0000 | pc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [31:0] pc);
    r_in_valid = valid;
    r_in_pc    = pc;
    r_in_instr = mk_instr(pc);
  endtask

  logic [31:0] q[$];
  int          pushed;
  logic        do_push;
  logic        do_pop;
  logic [31:0] wpc;

  initial begin
    rst         = 1'b0;
    r_flush     = 1'b0;
    r_out_ready = 1'b0;
    drive(1'b0, 32'h0);

    // reset state, checked before any clock edge
    #3;
    chk("rst_outValid", {31'd0, u_if2.outValid}, 32'd0);
    chk("rst_inReady",  {31'd0, u_if2.inReady},  32'd1);
    chk("rst_outPC",    u_if2.outPC,             32'd0);
    chk("rst_outInstr", u_if2.outInstruction,    32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // streaming with outReady=1
    r_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4));
      step();
      chk("stream_valid2",   {31'd0, u_if2.outValid}, 32'd1);
      chk("stream_pc2",      u_if2.outPC,             32'(i * 4));
      chk("stream_instr2",   u_if2.outInstruction,    mk_instr(32'(i * 4)));
      chk("stream_inReady2", {31'd0, u_if2.inReady},  32'd1);
      chk("stream_pc4",      u_if4.outPC,             32'(i * 4));
    end
    drive(1'b0, 32'h0);
    step();
    chk("stream_drain_valid", {31'd0, u_if2.outValid}, 32'd0);
    chk("stream_drain_pc",    u_if2.outPC,             32'd0);

    // fill / stall on DEPTH=2
    r_out_ready = 1'b0;
    drive(1'b1, 32'h100);
    step();
    chk("fill1_inReady", {31'd0, u_if2.inReady}, 32'd1);
    chk("fill1_pc",      u_if2.outPC,            32'h100);
    drive(1'b1, 32'h104);
    step();
    chk("fill2_inReady", {31'd0, u_if2.inReady}, 32'd0);
    chk("fill2_pc",      u_if2.outPC,            32'h100);
    drive(1'b1, 32'h108);
    step();
    chk("full_ignore_inReady", {31'd0, u_if2.inReady}, 32'd0);
    chk("full_hold_pc",        u_if2.outPC,            32'h100);
    chk("full_hold_instr",     u_if2.outInstruction,   mk_instr(32'h100));
    drive(1'b0, 32'h0);
    r_out_ready = 1'b1;
    #1;
    chk("release_pc0", u_if2.outPC, 32'h100);
    step();
    chk("release_pc1", u_if2.outPC, 32'h104);
    chk("release_inReady", {31'd0, u_if2.inReady}, 32'd1);
    step();
    chk("release_empty", {31'd0, u_if2.outValid}, 32'd0);

    // flush with two entries and a same-cycle push
    r_out_ready = 1'b0;
    drive(1'b1, 32'h180);
    step();
    drive(1'b1, 32'h184);
    step();
    chk("preflush_full", {31'd0, u_if2.inReady}, 32'd0);
    r_flush = 1'b1;
    drive(1'b1, 32'h200);
    step();
    r_flush = 1'b0;
    chk("flush_valid2",   {31'd0, u_if2.outValid}, 32'd0);
    chk("flush_instr2",   u_if2.outInstruction,    32'd0);
    chk("flush_pc2",      u_if2.outPC,             32'd0);
    chk("flush_inReady2", {31'd0, u_if2.inReady},  32'd1);
    chk("flush_valid4",   {31'd0, u_if4.outValid}, 32'd0);
    drive(1'b1, 32'h300);
    step();
    chk("postflush_pc2", u_if2.outPC, 32'h300);
    chk("postflush_pc4", u_if4.outPC, 32'h300);
    drive(1'b0, 32'h0);
    r_out_ready = 1'b1;
    step();
    chk("postflush_empty2", {31'd0, u_if2.outValid}, 32'd0);
    chk("postflush_empty4", {31'd0, u_if4.outValid}, 32'd0);

    // simultaneous push and pop at count=1
    r_out_ready = 1'b0;
    drive(1'b1, 32'h400);
    step();
    r_out_ready = 1'b1;
    drive(1'b1, 32'h404);
    step();
    chk("simul_pc",      u_if2.outPC,            32'h404);
    chk("simul_inReady", {31'd0, u_if2.inReady}, 32'd1);
    drive(1'b0, 32'h0);
    step();
    chk("simul_count1", {31'd0, u_if2.outValid}, 32'd0);

    // asynchronous reset between edges
    r_out_ready = 1'b0;
    drive(1'b1, 32'h500);
    step();
    drive(1'b1, 32'h504);
    step();
    drive(1'b0, 32'h0);
    chk("prerst_full", {31'd0, u_if2.inReady}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid2",   {31'd0, u_if2.outValid}, 32'd0);
    chk("arst_inReady2", {31'd0, u_if2.inReady},  32'd1);
    chk("arst_pc2",      u_if2.outPC,             32'd0);
    chk("arst_valid4",   {31'd0, u_if4.outValid}, 32'd0);
    #1 rst = 1'b1;
    drive(1'b1, 32'h600);
    step();
    chk("arst_resume_pc",    u_if2.outPC,            32'h600);
    chk("arst_resume_valid", {31'd0, u_if2.outValid}, 32'd1);
    drive(1'b0, 32'h0);
    r_out_ready = 1'b1;
    step();
    chk("arst_drain4", {31'd0, u_if4.outValid}, 32'd0);

    // wrap-around on DEPTH=4 with random outReady
    pushed = 0;
    for (int c = 0; c < 80 && (pushed < 10 || q.size() != 0); c++) begin
      r_out_ready = 1'($urandom_range(0, 1));
      wpc = 32'h700 + 32'(pushed * 4);
      drive(pushed < 10, wpc);
      chk("wrap_valid",   {31'd0, u_if4.outValid}, {31'd0, q.size() != 0});
      chk("wrap_inReady", {31'd0, u_if4.inReady},  {31'd0, q.size() < 4});
      if (q.size() != 0) begin
        chk("wrap_pc",    u_if4.outPC,          q[0]);
        chk("wrap_instr", u_if4.outInstruction, mk_instr(q[0]));
      end
      do_pop  = r_out_ready && (q.size() != 0);
      do_push = r_in_valid && (q.size() < 4);
      step();
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(wpc);
        pushed++;
      end
    end
    drive(1'b0, 32'h0);
    chk("wrap_pushed",    32'(pushed),   32'd10);
    chk("wrap_drained",   32'(q.size()), 32'd0);
    chk("wrap_end_valid", {31'd0, u_if4.outValid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
